// File: rtl/uart_rx_fifo_if.sv
// Receiver/FIFO bundle: serial line in, show-ahead FIFO read side and status out.
// The slave modport is the receiver; the master modport is its consumer.
interface uart_rx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic            rx;
  logic            rd_en;
  logic            clr_err;
  logic [7:0]      rd_data;
  logic            empty;
  logic            full;
  logic [CntW-1:0] count;
  logic            frame_err;
  logic            overrun;
  logic            rx_toggle;

  modport master (
    output rx, rd_en, clr_err,
    input  rd_data, empty, full, count, frame_err, overrun, rx_toggle
  );

  modport slave (
    input  rx, rd_en, clr_err,
    output rd_data, empty, full, count, frame_err, overrun, rx_toggle
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 receiver feeding a small show-ahead byte FIFO, with sticky
// framing/overrun flags and a per-valid-byte toggle for the display stage.
module uart_rx_fifo #(
  parameter int unsigned CLK_FRQ    = 25000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OSR        = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_fifo_if.slave  bus
);

  localparam int unsigned DIV  = CLK_FRQ / (BAUD * OSR);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SmpW = $clog2(OSR);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHi} state_e;

  state_e            state_q, state_d;
  logic              rx_meta_q, rx_s_q;
  logic [DivW-1:0]   div_q, div_d;
  logic [SmpW-1:0]   smp_q, smp_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              toggle_q, toggle_d;
  logic [7:0]        mem [FIFO_DEPTH];

  logic tick, byte_ok, frame_set, empty, full, push, pop;

  // Receiver FSM, tick divider and sample counting
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    smp_d     = smp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_ok   = 1'b0;
    frame_set = 1'b0;
    tick      = (state_q != StIdle) && (div_q == DivW'(DIV - 1));

    if (state_q == StIdle || tick) div_d = '0;
    else                           div_d = div_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        smp_d = '0;
        bit_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (tick) begin
          if (smp_q == SmpW'(OSR / 2 - 1)) begin
            smp_d   = '0;
            // A start bit that is high again at mid-bit was a glitch
            state_d = rx_s_q ? StIdle : StData;
          end else begin
            smp_d = smp_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (smp_q == SmpW'(OSR - 1)) begin
            smp_d   = '0;
            shift_d = {rx_s_q, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == 3'd7) state_d = StStop;
          end else begin
            smp_d = smp_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (smp_q == SmpW'(OSR - 1)) begin
            smp_d = '0;
            if (rx_s_q) begin
              byte_ok = 1'b1;
              state_d = StIdle;
            end else begin
              frame_set = 1'b1;
              state_d   = StWaitHi;
            end
          end else begin
            smp_d = smp_q + 1'b1;
          end
        end
      end
      StWaitHi: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO bookkeeping and sticky flags
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CntW'(FIFO_DEPTH));
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    push     = byte_ok && (!full || bus.rd_en);
    pop      = bus.rd_en && !empty;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    toggle_d    = toggle_q ^ byte_ok;
    frame_err_d = bus.clr_err ? 1'b0 : frame_err_q;
    overrun_d   = bus.clr_err ? 1'b0 : overrun_q;
    if (frame_set)        frame_err_d = 1'b1;
    if (byte_ok && !push) overrun_d   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      div_q       <= '0;
      smp_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      toggle_q    <= 1'b0;
    end else begin
      rx_meta_q   <= bus.rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      div_q       <= div_d;
      smp_q       <= smp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      toggle_q    <= toggle_d;
    end
  end

  // Storage needs no reset: nothing is readable until the count says so
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= shift_q;
  end

  assign bus.rd_data   = empty ? 8'h00 : mem[rd_ptr_q];
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.rx_toggle = toggle_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DIV=10 (160 clocks per bit); expected
// values are hand-derived constants plus a tracked rx_toggle value.
module tb_uart_rx_fifo;

  localparam int unsigned BitClks = 160;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic exp_tog = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.FIFO_DEPTH(4)) bus ();

  uart_rx_fifo #(
    .CLK_FRQ   (1536000),
    .BAUD      (9600),
    .OSR       (16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Start edge is driven on a negedge; the stop-bit sample tick then lands on
  // the 1523rd posedge after it, so pop_at_push raises rd_en for that edge.
  task automatic send_byte(input logic [7:0] data, input logic stop, input logic pop_at_push);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          bus.rx = frame[i];
          repeat (BitClks) @(negedge clk);
        end
      end
      begin
        if (pop_at_push) begin
          repeat (1522) @(posedge clk);
          @(negedge clk);
          bus.rd_en = 1'b1;
          @(negedge clk);
          bus.rd_en = 1'b0;
        end
      end
    join
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check(tag, 32'(bus.rd_data), 32'(exp));
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_clr;
    @(negedge clk);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  initial begin
    bus.rx      = 1'b1;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'h00);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_toggle", 32'(bus.rx_toggle), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Single byte, then pop; rd_en on empty must not underflow
    send_byte(8'hA5, 1'b1, 1'b0);
    exp_tog = ~exp_tog;
    check("a5_empty", 32'(bus.empty), 32'd0);
    check("a5_count", 32'(bus.count), 32'd1);
    check("a5_toggle", 32'(bus.rx_toggle), 32'(exp_tog));
    pop_check("a5_data", 8'hA5);
    check("a5_pop_empty", 32'(bus.empty), 32'd1);
    check("a5_pop_rd_data", 32'(bus.rd_data), 32'h00);
    pop_check("empty_pop_data", 8'h00);
    check("empty_pop_count", 32'(bus.count), 32'd0);

    // Start-bit glitch of 3 sample ticks
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (30) @(negedge clk);
    bus.rx = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_count", 32'(bus.count), 32'd0);
    check("glitch_toggle", 32'(bus.rx_toggle), 32'(exp_tog));
    check("glitch_frame_err", 32'(bus.frame_err), 32'd0);
    check("glitch_overrun", 32'(bus.overrun), 32'd0);

    // Framing error followed by a long break, then a good byte
    send_byte(8'h5A, 1'b0, 1'b0);
    repeat (20 * BitClks) @(negedge clk);
    bus.rx = 1'b1;
    repeat (100) @(negedge clk);
    check("brk_frame_err", 32'(bus.frame_err), 32'd1);
    check("brk_count", 32'(bus.count), 32'd0);
    check("brk_toggle", 32'(bus.rx_toggle), 32'(exp_tog));
    send_byte(8'h3C, 1'b1, 1'b0);
    exp_tog = ~exp_tog;
    check("3c_count", 32'(bus.count), 32'd1);
    check("3c_toggle", 32'(bus.rx_toggle), 32'(exp_tog));
    pop_check("3c_data", 8'h3C);

    // Overflow: five bytes into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1, 1'b0);
      exp_tog = ~exp_tog;
    end
    check("ovf_count", 32'(bus.count), 32'd4);
    check("ovf_full", 32'(bus.full), 32'd1);
    check("ovf_overrun", 32'(bus.overrun), 32'd1);
    check("ovf_toggle", 32'(bus.rx_toggle), 32'(exp_tog));
    pop_check("ovf_pop0", 8'h01);
    pop_check("ovf_pop1", 8'h02);
    pop_check("ovf_pop2", 8'h03);
    pop_check("ovf_pop3", 8'h04);
    check("ovf_drained", 32'(bus.empty), 32'd1);

    // Full FIFO with a pop in the cycle of the 5th push
    pulse_clr();
    check("clr_overrun", 32'(bus.overrun), 32'd0);
    check("clr_frame_err", 32'(bus.frame_err), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      send_byte(8'(i), 1'b1, 1'b0);
      exp_tog = ~exp_tog;
    end
    check("pp_full", 32'(bus.full), 32'd1);
    send_byte(8'h05, 1'b1, 1'b1);
    exp_tog = ~exp_tog;
    check("pp_count", 32'(bus.count), 32'd4);
    check("pp_overrun", 32'(bus.overrun), 32'd0);
    check("pp_toggle", 32'(bus.rx_toggle), 32'(exp_tog));
    pop_check("pp_pop0", 8'h02);
    pop_check("pp_pop1", 8'h03);
    pop_check("pp_pop2", 8'h04);
    pop_check("pp_pop3", 8'h05);
    pulse_clr();
    check("end_overrun", 32'(bus.overrun), 32'd0);
    check("end_frame_err", 32'(bus.frame_err), 32'd0);

    // Reset in the middle of bit 4, with a byte already buffered
    send_byte(8'h77, 1'b1, 1'b0);
    check("pre_rst_count", 32'(bus.count), 32'd1);
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (BitClks) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = i[0];
      repeat (BitClks) @(negedge clk);
    end
    bus.rx = 1'b1;
    repeat (BitClks / 2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_empty", 32'(bus.empty), 32'd1);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_rd_data", 32'(bus.rd_data), 32'h00);
    check("mid_rst_toggle", 32'(bus.rx_toggle), 32'd0);
    exp_tog = 1'b0;
    repeat (10) @(negedge clk);
    bus.rx = 1'b1;
    rst_n  = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'hC3, 1'b1, 1'b0);
    exp_tog = ~exp_tog;
    check("c3_count", 32'(bus.count), 32'd1);
    check("c3_toggle", 32'(bus.rx_toggle), 32'(exp_tog));
    check("c3_frame_err", 32'(bus.frame_err), 32'd0);
    pop_check("c3_data", 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
